// File: rtl/serial_tx_unit_if.sv
// Handshake/data bundle between the calculator controller and serial_tx_unit.
// master: controller side (issues capture/transmit requests, supplies the word).
// slave:  serializer side (returns the serial bit, valid, done and busy).
interface serial_tx_unit_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  sampleData;
  logic                  txData;
  logic [DATA_WIDTH-1:0] dataIn;
  logic                  dataOut;
  logic                  txValid;
  logic                  txDone;
  logic                  busy;

  modport master (
    output sampleData,
    output txData,
    output dataIn,
    input  dataOut,
    input  txValid,
    input  txDone,
    input  busy
  );

  modport slave (
    input  sampleData,
    input  txData,
    input  dataIn,
    output dataOut,
    output txValid,
    output txDone,
    output busy
  );
endinterface

// File: rtl/serial_tx_unit.sv
// serial_tx_unit: captures a parallel result word and shifts it out LSB-first,
// then pulses txDone for one cycle to release the controller.
// Optional feature macro: PARITY_EN -- appends the even parity bit of the
// captured word after the MSB, making the SHIFT phase one cycle longer.
// Port names clk/reset follow the controller's naming; reset is async, active-low.
module serial_tx_unit #(
  parameter int DATA_WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  serial_tx_unit_if.slave  bus
);

`ifdef PARITY_EN
  localparam int SR_W = DATA_WIDTH + 1;
`else
  localparam int SR_W = DATA_WIDTH;
`endif

  localparam int              CNT_W    = $clog2(DATA_WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SR_W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [SR_W-1:0]  r_shreg;
  logic [CNT_W-1:0] r_cnt;
  logic [SR_W-1:0]  w_capture;

  // Word loaded on capture; with parity the bit above the MSB carries ^word.
`ifdef PARITY_EN
  assign w_capture = {^bus.dataIn, bus.dataIn};
`else
  assign w_capture = bus.dataIn;
`endif

  // Serializer FSM, shift register and bit counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: the shift register is reset too, so a transmit straight after reset
  // sends a defined all-zero word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Capture takes priority over a transmit request in the same cycle.
          if (bus.sampleData) begin
            r_shreg <= w_capture;
            r_state <= S_HOLD;
          end else if (bus.txData) begin
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_HOLD: begin
          if (bus.sampleData) begin
            r_shreg <= w_capture;
          end
          if (bus.txData) begin
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_shreg <= r_shreg >> 1;
          if (r_cnt == LAST_IDX) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded purely from registered state, so reset clears them at once.
  // NOTE: every output gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    bus.txValid = 1'b0;
    bus.dataOut = 1'b0;
    bus.txDone  = 1'b0;
    bus.busy    = (r_state != S_IDLE);
    case (r_state)
      S_SHIFT: begin
        bus.txValid = 1'b1;
        bus.dataOut = r_shreg[0];
      end
      S_DONE: begin
        bus.txDone = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_serial_tx_unit.sv
// Self-checking bench for serial_tx_unit (DATA_WIDTH=8), table-driven
// transfers plus hand-written reset and idle-transmit sequences.
// Honours PARITY_EN so the same bench covers both builds.
module tb_serial_tx_unit;

  localparam int DW = 8;
`ifdef PARITY_EN
  localparam int NB = DW + 1;
`else
  localparam int NB = DW;
`endif

  localparam int M_SEP   = 0;  // capture cycle, then txData
  localparam int M_SIMUL = 1;  // sampleData and txData together in IDLE
  localparam int M_RECAP = 2;  // capture 8'h55, then recapture + txData in HOLD

  typedef struct {
    string      name;
    logic [7:0] data;
    int         mode;
    int         glitch_at;  // bit index at which a stray capture of 8'hFF is issued, -1 none
    logic [8:0] exp;        // expected bits in send order, bit i sent i-th; bit 8 = parity
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  vec_t vecs[5];

  serial_tx_unit_if #(.DATA_WIDTH(DW)) bus ();

  serial_tx_unit #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"},    32'(bus.busy),    32'd0);
    check({tag, " txValid"}, 32'(bus.txValid), 32'd0);
    check({tag, " dataOut"}, 32'(bus.dataOut), 32'd0);
    check({tag, " txDone"},  32'(bus.txDone),  32'd0);
  endtask

  // Runs the SHIFT and DONE phases; DUT must be entering SHIFT at the last edge.
  task automatic shift_and_done(input string name, input int glitch_at, input logic [8:0] exp);
    for (int i = 0; i < NB; i++) begin
      check($sformatf("%s bit%0d dataOut", name, i), 32'(bus.dataOut), 32'(exp[i]));
      check($sformatf("%s bit%0d txValid", name, i), 32'(bus.txValid), 32'd1);
      check($sformatf("%s bit%0d busy", name, i),    32'(bus.busy),    32'd1);
      check($sformatf("%s bit%0d txDone", name, i),  32'(bus.txDone),  32'd0);
      if (i == glitch_at) begin
        bus.sampleData = 1'b1;
        bus.dataIn     = 8'hFF;
      end else begin
        bus.sampleData = 1'b0;
      end
      tick();
    end
    check({name, " done txDone"},  32'(bus.txDone),  32'd1);
    check({name, " done txValid"}, 32'(bus.txValid), 32'd0);
    check({name, " done dataOut"}, 32'(bus.dataOut), 32'd0);
    check({name, " done busy"},    32'(bus.busy),    32'd1);
    bus.txData = 1'b0;
    tick();
    check_idle({name, " after"});
  endtask

  task automatic run_transfer(input string name, input logic [7:0] data, input int mode,
                              input int glitch_at, input logic [8:0] exp);
    bus.txData     = 1'b0;
    bus.sampleData = 1'b1;
    bus.dataIn     = (mode == M_RECAP) ? 8'h55 : data;
    if (mode == M_SIMUL) bus.txData = 1'b1;
    tick();
    check({name, " hold busy"},    32'(bus.busy),    32'd1);
    check({name, " hold txValid"}, 32'(bus.txValid), 32'd0);
    if (mode == M_RECAP) begin
      bus.dataIn     = data;
      bus.sampleData = 1'b1;
    end else begin
      bus.sampleData = 1'b0;
    end
    bus.txData = 1'b1;
    tick();
    bus.sampleData = 1'b0;
    shift_and_done(name, glitch_at, exp);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    // Hand-computed LSB-first sequences; parity bit 8 is even parity of the word.
    vecs[0] = '{name: "a5_sep",    data: 8'hA5, mode: M_SEP,   glitch_at: -1, exp: 9'b0_1010_0101};
    vecs[1] = '{name: "3c_simul",  data: 8'h3C, mode: M_SIMUL, glitch_at: -1, exp: 9'b0_0011_1100};
    vecs[2] = '{name: "a5_glitch", data: 8'hA5, mode: M_SEP,   glitch_at: 2,  exp: 9'b0_1010_0101};
    vecs[3] = '{name: "c3_recap",  data: 8'hC3, mode: M_RECAP, glitch_at: -1, exp: 9'b0_1100_0011};
    vecs[4] = '{name: "07_sep",    data: 8'h07, mode: M_SEP,   glitch_at: -1, exp: 9'b1_0000_0111};

    rst_n          = 1'b0;
    bus.sampleData = 1'b0;
    bus.txData     = 1'b0;
    bus.dataIn     = '0;
    #1;
    check_idle("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_idle("post_reset");

    for (int v = 0; v < 5; v++) begin
      run_transfer(vecs[v].name, vecs[v].data, vecs[v].mode, vecs[v].glitch_at, vecs[v].exp);
    end

    // Reset mid-shift of 8'hA5 at bit 3: outputs clear at once, no txDone follows.
    bus.sampleData = 1'b1;
    bus.dataIn     = 8'hA5;
    tick();
    bus.sampleData = 1'b0;
    bus.txData     = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("abort bit%0d txValid", i), 32'(bus.txValid), 32'd1);
      if (i < 3) tick();
    end
    rst_n      = 1'b0;
    bus.txData = 1'b0;
    #1;
    check_idle("abort reset");
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("abort held txDone%0d", i), 32'(bus.txDone), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check_idle("abort release");
    tick();
    check("abort no late txDone", 32'(bus.txDone), 32'd0);
    run_transfer("81_after_abort", 8'h81, M_SEP, -1, 9'b0_1000_0001);

    // txData alone in IDLE resends the held word, which is all zero once shifted out.
    bus.txData = 1'b1;
    tick();
    shift_and_done("idle_tx", -1, 9'b0_0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
